// File: rtl/mult_accum_pkg.sv
// mult_accum_pkg: shared types and widths for the multiply-accumulate block
package mult_accum_pkg;
    localparam int LEN_W = 4;
    localparam int OP_W  = 8;
    typedef enum logic [1:0] {IDLE, ACC, DONE} state_t;
endpackage

// File: rtl/mult_accum_mul.sv
// mult_accum_mul: combinational 8x8 multiplier stage
//   a, b : operands
//   prod : low OP_W bits of the product
//   ovf  : product does not fit in OP_W bits
module mult_accum_mul
    import mult_accum_pkg::*;
(
    input  logic [OP_W-1:0] a,
    input  logic [OP_W-1:0] b,
    output logic [OP_W-1:0] prod,
    output logic            ovf
);
    logic [2*OP_W-1:0] full;
    assign full = a * b;
    assign prod = full[OP_W-1:0];
    assign ovf  = |full[2*OP_W-1:OP_W];
endmodule

// File: rtl/mult_accum.sv
// mult_accum: saturating multiply-accumulate over a job of lenIn operand pairs
//   clk, rst_n            : clock, asynchronous active-low reset
//   startIn, lenIn        : job start (taken in IDLE) and pair count
//   aIn, bIn, inValid     : operand pair and its valid, accepted when inReady
//   inReady               : high while accumulating
//   accOut, errorOut      : live accumulator and sticky error
//   outValid, outReady    : result handshake in DONE
//   busy                  : high outside IDLE
module mult_accum
    import mult_accum_pkg::*;
#(
    parameter int ACC_W = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             startIn,
    input  logic [LEN_W-1:0] lenIn,
    input  logic [OP_W-1:0]  aIn,
    input  logic [OP_W-1:0]  bIn,
    input  logic             inValid,
    output logic             inReady,
    output logic [ACC_W-1:0] accOut,
    output logic             errorOut,
    output logic             outValid,
    input  logic             outReady,
    output logic             busy
);
    state_t           state;
    logic [LEN_W-1:0] count;
    logic [ACC_W-1:0] acc;
    logic             err;
    logic [OP_W-1:0]  prod;
    logic             ovf;
    logic [ACC_W:0]   sum;
    logic             sat;
    logic [ACC_W-1:0] acc_next;
    logic             accept;

    mult_accum_mul u_mul (
        .a    (aIn),
        .b    (bIn),
        .prod (prod),
        .ovf  (ovf)
    );

    // One extra bit catches the carry that signals saturation.
    assign sum      = {1'b0, acc} + {{(ACC_W+1-OP_W){1'b0}}, prod};
    assign sat      = sum[ACC_W];
    assign acc_next = sat ? '1 : sum[ACC_W-1:0];

    assign inReady  = (state == ACC);
    assign accept   = inValid & inReady;
    assign outValid = (state == DONE);
    assign busy     = (state != IDLE);
    assign accOut   = acc;
    assign errorOut = err;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
            count <= '0;
            acc   <= '0;
            err   <= 1'b0;
        end else begin
            case (state)
                IDLE: if (startIn) begin
                    acc   <= '0;
                    err   <= 1'b0;
                    count <= lenIn;
                    state <= (lenIn == '0) ? DONE : ACC;
                end
                ACC: if (accept) begin
                    acc   <= acc_next;
                    err   <= err | ovf | sat;
                    count <= count - LEN_W'(1);
                    if (count == LEN_W'(1)) state <= DONE;
                end
                DONE: if (outReady) state <= IDLE;
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: doc/mult_accum.md
MULT_ACCUM -- requirements
Module: mult_accum

Interface
REQ-001 Parameter ACC_W, default 16, accumulator width in bits; legal range 9..24.
REQ-002 clk  input  1  sole clock; all state updates on the rising edge.
REQ-003 rst_n  input  1  reset; asynchronous and active-low.
REQ-004 startIn  input  1  single-cycle job start; sampled only in IDLE.
REQ-005 lenIn  input  4  number of operand pairs in the job; captured when startIn is taken.
REQ-006 aIn  input  8  multiplicand for the current pair.
REQ-007 bIn  input  8  multiplier for the current pair.
REQ-008 inValid  input  1  aIn/bIn hold a valid pair.
REQ-009 inReady  output  1  block accepts a pair this cycle.
REQ-010 accOut  output  ACC_W  job result, unsigned.
REQ-011 errorOut  output  1  sticky job error flag.
REQ-012 outValid  output  1  accOut/errorOut hold a valid result.
REQ-013 outReady  input  1  downstream takes the result.
REQ-014 busy  output  1  high in every state except IDLE.

Function
REQ-015 FSM states SHALL be IDLE, ACC and DONE, with no other states.
REQ-016 IDLE: startIn=1 with lenIn>0 -> ACC; remaining count <= lenIn, acc <= 0, error <= 0.
REQ-017 IDLE: startIn=1 with lenIn=0 -> DONE directly; acc <= 0, error <= 0.
REQ-018 inReady SHALL equal (state==ACC) and be purely combinational from state, with no dependency on inValid.
REQ-019 A pair is accepted on any cycle with inValid & inReady; the product SHALL come from the 8x8 multiplier stage as an 8-bit low product plus an overflow flag.
REQ-020 On accept: acc <= min(acc + product, 2^ACC_W-1); product is zero-extended; count decrements by 1.
REQ-021 On accept: error |= multiplier overflow flag | addition saturated.
REQ-022 Accept with count==1 -> DONE on the next edge; accumulate latency SHALL be one cycle from accept.
REQ-023 DONE: outValid=1; accOut and errorOut SHALL hold stable until outValid & outReady; that handshake -> IDLE.
REQ-024 startIn SHALL be ignored in ACC and DONE; inValid SHALL be ignored outside ACC.
REQ-025 accOut and errorOut SHALL reflect the live accumulator and error registers in every state; consumers SHALL qualify them with outValid.

Reset
REQ-026 rst_n low SHALL immediately force state=IDLE, acc=0, error=0, count=0.
REQ-027 While rst_n is low, outputs SHALL be inReady=0, outValid=0, busy=0, accOut=0, errorOut=0, including when reset hits mid-job.
REQ-028 After rst_n deasserts, the first edge SHALL be able to accept startIn.

Structure
REQ-029 A shared package SHALL hold the state enum (IDLE/ACC/DONE), the lenIn width constant (4) and the operand width constant (8).
REQ-030 Exactly one sub-module SHALL be instantiated: the existing 8x8 multiplier stage, fed combinationally from aIn/bIn, with its result and error outputs consumed as described in REQ-019.
REQ-031 Saturation, counter and FSM logic SHALL be local to mult_accum.

Verification
REQ-032 Single pair: start, len=1, pair (3,5) -> inReady high 1 cycle after start; accOut=15, errorOut=0, outValid 2 cycles after start.
REQ-033 Multi-pair: len=3, pairs (10,10),(20,5),(7,7), with inValid gaps of 2 cycles -> accOut=249, errorOut=0.
REQ-034 Product overflow: len=2, pairs (16,16),(2,3) -> multiplier low byte 0 then 6; accOut=6, errorOut=1.
REQ-035 Saturation: with ACC_W=10, len=5, pairs (15,17) x5 -> accOut=1023, errorOut=1.
REQ-036 Backpressure: outReady low 5 cycles in DONE with startIn pulsed meanwhile -> accOut stable, start ignored; one-cycle outReady -> IDLE.
REQ-037 Reset mid-job: rst_n low after 2 of 4 accepts -> all outputs 0 immediately, state IDLE; a new len=0 job -> accOut=0, outValid next cycle.
